// File: rtl/adder_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : adder_multiplier                                             |
// | Description : Pipelined sign-magnitude fixed-point adder / multiplier.     |
// |               WIDTH-bit words (MSB = sign), FRAC fractional bits.          |
// |               Fixed 2-cycle latency after the sampling edge, one op/clk.   |
// |               Optional macro ADDER_MULTIPLIER_SATURATE_EN: clamp the       |
// |               magnitude on overflow instead of wrapping it.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module adder_multiplier #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  localparam int MAG = WIDTH - 1;  // magnitude bits
  localparam int PW  = 2 * MAG;    // full-precision intermediate width

  // Stage 1: sampled operands
  logic             s1_valid;
  logic             s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: unclipped result
  logic             s2_valid;
  logic             s2_sign;
  logic [PW-1:0]    s2_mag;

  // Stage-1 combinational datapath
  logic [MAG-1:0]   mag_a;
  logic [MAG-1:0]   mag_b;
  logic             sign_a;
  logic             sign_b;
  logic [PW-1:0]    ext_a;
  logic [PW-1:0]    ext_b;
  logic [PW-1:0]    product;
  logic [PW-1:0]    raw_mag;
  logic             raw_sign;

  // Stage-2 combinational result shaping
  logic             ovf_next;
  logic [MAG-1:0]   clip_mag;
  logic             sign_next;

  // Capture operands; data only moves on valid to avoid needless toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op;
        s1_a  <= a;
        s1_b  <= b;
      end
    end
  end

  // Compute the full-precision signed-magnitude result; -0 inputs read as +0
  always_comb begin
    mag_a    = s1_a[MAG-1:0];
    mag_b    = s1_b[MAG-1:0];
    sign_a   = s1_a[WIDTH-1] & (|mag_a);
    sign_b   = s1_b[WIDTH-1] & (|mag_b);
    ext_a    = PW'(mag_a);
    ext_b    = PW'(mag_b);
    product  = ext_a * ext_b;
    raw_mag  = '0;
    raw_sign = 1'b0;
    if (s1_op) begin
      raw_mag  = product >> FRAC;
      raw_sign = sign_a ^ sign_b;
    end else if (sign_a == sign_b) begin
      raw_mag  = ext_a + ext_b;
      raw_sign = sign_a;
    end else if (mag_a >= mag_b) begin
      raw_mag  = ext_a - ext_b;
      raw_sign = sign_a;
    end else begin
      raw_mag  = ext_b - ext_a;
      raw_sign = sign_b;
    end
  end

  // Register the unclipped result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_mag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= raw_sign;
        s2_mag  <= raw_mag;
      end
    end
  end

  // Detect overflow, clamp or wrap, and force any zero result to +0
  always_comb begin
    ovf_next = |s2_mag[PW-1:MAG];
`ifdef ADDER_MULTIPLIER_SATURATE_EN
    clip_mag = ovf_next ? {MAG{1'b1}} : s2_mag[MAG-1:0];
`else
    clip_mag = s2_mag[MAG-1:0];
`endif
    sign_next = s2_sign & (|clip_mag);
  end

  // Output register; y and ovf hold between valid results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        y   <= {sign_next, clip_mag};
        ovf <= ovf_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_adder_multiplier                                          |
// | Description : Scoreboard bench for adder_multiplier: directed vectors,     |
// |               streaming, random traffic and reset mid-flight.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_adder_multiplier;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;
  localparam longint MAXMAG = (longint'(1) << (WIDTH - 1)) - 1;
`ifdef ADDER_MULTIPLIER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             op = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             ovf;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             ovf;
    int               due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [WIDTH-1:0] last_y = '0;
  logic             last_ovf = 1'b0;

  adder_multiplier #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .y        (y),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Count rising edges so expected output times can be stated as edge numbers
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: treat words as signed numbers and use ordinary arithmetic
  function automatic void model(input logic op_i, input logic [WIDTH-1:0] a_i,
                                input logic [WIDTH-1:0] b_i,
                                output logic [WIDTH-1:0] y_o, output logic ovf_o);
    longint va, vb, v, mag;
    bit neg;
    va = longint'(a_i[WIDTH-2:0]);
    vb = longint'(b_i[WIDTH-2:0]);
    if (!op_i) begin
      if (a_i[WIDTH-1]) va = -va;
      if (b_i[WIDTH-1]) vb = -vb;
      v   = va + vb;
      neg = (v < 0);
      mag = neg ? -v : v;
    end else begin
      mag = (va * vb) / (longint'(1) << FRAC);
      neg = a_i[WIDTH-1] ^ b_i[WIDTH-1];
    end
    ovf_o = (mag > MAXMAG);
    if (ovf_o) mag = SAT ? MAXMAG : (mag % (MAXMAG + 1));
    if (mag == 0) neg = 1'b0;
    y_o = {neg, mag[WIDTH-2:0]};
  endfunction

  // Drive one operation with an explicit expected result
  task automatic issue_exp(input logic op_i, input logic [WIDTH-1:0] a_i,
                           input logic [WIDTH-1:0] b_i,
                           input logic [WIDTH-1:0] y_e, input logic ovf_e);
    exp_t e;
    @(negedge clk); #1;
    in_valid = 1'b1; op = op_i; a = a_i; b = b_i;
    // sampled on edge cyc+1, visible after edge cyc+3
    e.y = y_e; e.ovf = ovf_e; e.due = cyc + 3;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic op_i, input logic [WIDTH-1:0] a_i,
                       input logic [WIDTH-1:0] b_i);
    logic [WIDTH-1:0] ye;
    logic             oe;
    model(op_i, a_i, b_i, ye, oe);
    issue_exp(op_i, a_i, b_i, ye, oe);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      in_valid = 1'b0;
      op = 1'($urandom); a = WIDTH'($urandom); b = WIDTH'($urandom);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = WIDTH'($urandom);
    case ($urandom % 5)
      0: w[WIDTH-2:0] = '0;                                  // +0 / -0
      1: w[WIDTH-2:0] = (WIDTH-1)'(MAXMAG - $urandom_range(0, 600));
      2: w[WIDTH-2:0] = (WIDTH-1)'($urandom_range(0, 1023));
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compares every cycle against the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    bit   exp_now;
    if (!rst_n) begin
      total++;
      if (out_valid !== 1'b0 || y !== '0 || ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: out_valid=%b y=%h ovf=%b, required 0 0000 0", out_valid, y, ovf);
      end
      last_y = '0; last_ovf = 1'b0;
    end else begin
      exp_now = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      total++;
      if (out_valid !== exp_now) begin
        bad++;
        $display("FAIL valid_timing: cycle=%0d out_valid=%b, required %b", cyc, out_valid, exp_now);
      end
      if (out_valid === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (y !== e.y || ovf !== e.ovf) begin
          bad++;
          $display("FAIL result: cycle=%0d y=%h ovf=%b, required y=%h ovf=%b", cyc, y, ovf, e.y, e.ovf);
        end
        last_y = y; last_ovf = ovf;
      end else begin
        if (exp_now) void'(sb_q.pop_front());
        if (out_valid === 1'b0) begin
          total++;
          if (y !== last_y || ovf !== last_ovf) begin
            bad++;
            $display("FAIL hold: cycle=%0d y=%h ovf=%b, required y=%h ovf=%b", cyc, y, ovf, last_y, last_ovf);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Directed vectors
    issue_exp(1'b0, 16'h0100, 16'h8100, 16'h0000, 1'b0);
    idle(1);
    issue_exp(1'b1, 16'h0200, 16'h8180, 16'h8300, 1'b0);
    issue_exp(1'b1, 16'h0080, 16'h0080, 16'h0040, 1'b0);
    issue_exp(1'b0, 16'h7F00, 16'h0200, SAT ? 16'h7FFF : 16'h0100, 1'b1);
    issue_exp(1'b0, 16'h8000, 16'h0000, 16'h0000, 1'b0);
    issue_exp(1'b1, 16'h8000, 16'h0100, 16'h0000, 1'b0);
    issue_exp(1'b0, 16'h8300, 16'h0100, 16'h8200, 1'b0);
    issue_exp(1'b1, 16'h7FFF, 16'h7FFF, SAT ? 16'h7FFF : 16'h7F00, 1'b1);
    idle(4);

    // Streaming: four back-to-back operations
    issue(1'b0, 16'h0123, 16'h0456);
    issue(1'b1, 16'h8300, 16'h0280);
    issue(1'b0, 16'h8500, 16'h0200);
    issue(1'b1, 16'h0001, 16'h0001);
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom % 4 != 0) issue(1'($urandom), rand_word(), rand_word());
      else idle(1);
    end
    idle(4);

    // Reset one cycle after a valid input: the operation must vanish
    issue(1'b0, 16'h0100, 16'h0100);
    @(negedge clk); #1;
    in_valid = 1'b0; rst_n = 1'b0;
    sb_q.delete();
    idle(2);
    @(negedge clk); #1 rst_n = 1'b1;
    idle(6);

    // Operation accepted right after reset release
    issue(1'b1, 16'h0300, 16'h8200);
    idle(6);

    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_multiplier.md
ADDER_MULTIPLIER -- requirements
Module: adder_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, total word width: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude.
REQ-002 SHALL have parameter FRAC, default 8, number of fractional magnitude bits, so 1.0 = 0x0100.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: operands and op are valid this cycle.
REQ-006 SHALL have port op, input, 1 bit: 0 = add, 1 = multiply.
REQ-007 SHALL have port a, input, WIDTH bits: sign-magnitude operand A.
REQ-008 SHALL have port b, input, WIDTH bits: sign-magnitude operand B.
REQ-009 SHALL have port out_valid, output, 1 bit: y and ovf are valid this cycle.
REQ-010 SHALL have port y, output, WIDTH bits: sign-magnitude result.
REQ-011 SHALL have port ovf, output, 1 bit: the result magnitude exceeded 2^(WIDTH-1)-1.

Function
REQ-012 SHALL accept one operation per clock while in_valid=1; there is no backpressure.
REQ-013 SHALL have a fixed latency of 2 cycles: inputs sampled at edge N appear on y, ovf and out_valid after edge N+2, for both op values.
REQ-014 SHALL drive out_valid=1 exactly 2 cycles after each accepted in_valid=1, and 0 otherwise; back-to-back inputs yield back-to-back outputs.
REQ-015 Add, equal signs: result magnitude = |a| + |b|, result sign = the common sign.
REQ-016 Add, differing signs: result magnitude = larger magnitude minus smaller magnitude, result sign = sign of the larger-magnitude operand.
REQ-017 Multiply: result sign = sign(a) XOR sign(b); result magnitude = (|a|*|b|) >> FRAC, truncated with no rounding, using a full 2*(WIDTH-1)-bit intermediate product.
REQ-018 SHALL treat negative zero (0x8000) as zero on input.
REQ-019 SHALL always output a zero result as +0 (0x0000).
REQ-020 SHALL set ovf=1 when the unclipped magnitude is greater than 0x7FFF; the overflowed value is then handled per REQ-025/REQ-026.
REQ-021 y and ovf SHALL hold their last values while out_valid=0.

Reset
REQ-022 While rst_n=0: y=0x0000, ovf=0, out_valid=0, and all pipeline valid bits are cleared, regardless of clk.
REQ-023 Operations in flight when rst_n asserts SHALL be discarded and never produce out_valid.
REQ-024 The first input accepted after reset is the edge where rst_n=1 and in_valid=1; its result follows the latency of REQ-013.

Configuration
REQ-025 With macro ADDER_MULTIPLIER_SATURATE_EN defined: on overflow the magnitude SHALL clamp to 0x7FFF and the sign SHALL be kept.
REQ-026 Without ADDER_MULTIPLIER_SATURATE_EN: on overflow the magnitude SHALL wrap to its low WIDTH-1 bits and the sign SHALL be kept; ovf SHALL still be asserted in both builds, and a wrapped magnitude of 0 is reported as +0 per REQ-019.

Verification
REQ-027 Add, cancellation: op=0, a=0x0100, b=0x8100 -> y=0x0000, ovf=0, out_valid 2 cycles later.
REQ-028 Multiply: op=1, a=0x0200, b=0x8180 -> y=0x8300 (-3.0), ovf=0; op=1, a=0x0080, b=0x0080 -> y=0x0040.
REQ-029 Add overflow: op=0, a=0x7F00, b=0x0200 -> ovf=1; y=0x7FFF with the SATURATE_EN build, y=0x0100 without it.
REQ-030 Negative zero: op=0, a=0x8000, b=0x0000 -> y=0x0000; op=1, a=0x8000, b=0x0100 -> y=0x0000.
REQ-031 Streaming: 4 consecutive valid inputs -> 4 consecutive out_valid pulses, in order, each 2 cycles after its input.
REQ-032 Reset mid-flight: assert rst_n=0 one cycle after a valid input -> y=0x0000, out_valid stays 0, and no stale result appears after release.
